// File: rtl/conv_row_pkg.sv
// Shared types and helpers for the multi-channel 1-D convolution row engine.
package conv_row_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } conv_row_state_t;

  localparam int NARROW_W = 64;

  function automatic int acc_width_f(input int dw, input int mfw, input int mch);
    return 2 * dw + $clog2(mfw * mch);
  endfunction

  // Clamp to the signed dw-bit range when sat is set; the caller keeps the low dw bits.
  function automatic logic signed [NARROW_W-1:0] narrow_f(input logic signed [NARROW_W-1:0] v,
                                                          input int dw, input bit sat);
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    hi = (NARROW_W'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_row_engine_ofifo.sv
// Synchronous output FIFO for the row engine; reports its free-slot count.
module conv_row_ofifo
  import conv_row_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic signed [DATA_WIDTH-1:0] i_push_data,
  input  logic                         i_pop,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic [CNT_W-1:0]             o_free
);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok  = i_pop && (cnt_q != '0);
    push_ok = i_push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    wr_d    = push_ok ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop_ok ? ptr_inc(rd_q) : rd_q;
    cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= i_push_data;
  end

  assign o_valid = (cnt_q != '0);
  assign o_data  = o_valid ? mem_q[rd_q] : '0;
  assign o_free  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/conv_row_engine.sv
// Multi-channel 1-D convolution row engine with psum buffer and output FIFO.
// Define CONV_ROW_SAT_EN to saturate outputs instead of wrapping them.
module conv_row_engine
  import conv_row_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_FILTER_WIDTH = 11,
  parameter int MAX_CHANNELS     = 4,
  parameter int MAX_IFMAP_WIDTH  = 64,
  parameter int OUT_FIFO_DEPTH   = 4,
  parameter int FRAC_BITS        = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_start,
  input  logic [$clog2(MAX_FILTER_WIDTH):0]   i_filter_width,
  input  logic [$clog2(MAX_FILTER_WIDTH):0]   i_stride,
  input  logic [$clog2(MAX_IFMAP_WIDTH):0]    i_ifmap_width,
  input  logic [$clog2(MAX_CHANNELS):0]       i_num_channels,
  input  logic signed [DATA_WIDTH-1:0]        i_weight_data,
  input  logic                                i_weight_valid,
  input  logic [$clog2(MAX_CHANNELS)-1:0]     i_weight_ch,
  input  logic [$clog2(MAX_FILTER_WIDTH)-1:0] i_weight_col,
  input  logic signed [DATA_WIDTH-1:0]        i_ifmap_data,
  input  logic                                i_ifmap_valid,
  output logic                                o_ifmap_ready,
  output logic signed [DATA_WIDTH-1:0]        o_psum_data,
  output logic                                o_psum_valid,
  input  logic                                i_psum_ready,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_cfg_err
);

  localparam int FW_W   = $clog2(MAX_FILTER_WIDTH) + 1;
  localparam int IW_W   = $clog2(MAX_IFMAP_WIDTH) + 1;
  localparam int CH_W   = $clog2(MAX_CHANNELS) + 1;
  localparam int WCH_W  = $clog2(MAX_CHANNELS);
  localparam int WCOL_W = $clog2(MAX_FILTER_WIDTH);
  localparam int OIDX_W = $clog2(MAX_IFMAP_WIDTH);
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int ACC_W  = acc_width_f(DATA_WIDTH, MAX_FILTER_WIDTH, MAX_CHANNELS);

`ifdef CONV_ROW_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  conv_row_state_t state_q, state_d;
  logic [FW_W-1:0]   f_q, f_d, s_q, s_d, ph_q, ph_d;
  logic [IW_W-1:0]   wdt_q, wdt_d, col_q, col_d;
  logic [CH_W-1:0]   c_q, c_d, ch_q, ch_d;
  logic [OIDX_W-1:0] o_q, o_d;
  logic              done_q, done_d, cfg_err_q, cfg_err_d;

  logic              s0_fire_q, s0_fire_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
  logic [WCH_W-1:0]  s0_ch_q, s0_ch_d;
  logic [OIDX_W-1:0] s0_o_q, s0_o_d;
  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [OIDX_W-1:0] s1_o_q;
  logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;

  logic signed [DATA_WIDTH-1:0] w_q   [MAX_CHANNELS][MAX_FILTER_WIDTH];
  logic signed [DATA_WIDTH-1:0] win_q [MAX_FILTER_WIDTH];
  logic signed [DATA_WIDTH-1:0] win_d [MAX_FILTER_WIDTH];
  logic signed [ACC_W-1:0]      psum_q [MAX_IFMAP_WIDTH];
  logic signed [2*DATA_WIDTH-1:0] lane_prod [MAX_FILTER_WIDTH];
  logic signed [ACC_W-1:0]        lane_sum  [MAX_FILTER_WIDTH+1];

  logic cfg_ok, xfer, ifmap_ready, col_at_tap, fire, col_last, ch_last;
  logic [1:0]       inflight;
  logic [CNT_W-1:0] fifo_free;
  logic             fifo_valid, push;
  logic signed [ACC_W-1:0]      acc_new, acc_shift;
  logic signed [DATA_WIDTH-1:0] push_data;

  assign cfg_ok = (i_filter_width != '0) && (32'(i_filter_width) <= 32'(MAX_FILTER_WIDTH))
               && (i_stride != '0) && (i_stride <= i_filter_width)
               && (32'(i_ifmap_width) >= 32'(i_filter_width))
               && (32'(i_ifmap_width) <= 32'(MAX_IFMAP_WIDTH))
               && (i_num_channels != '0) && (32'(i_num_channels) <= 32'(MAX_CHANNELS));

  // Only accept a pixel if every result already in flight still has a FIFO slot waiting.
  assign inflight    = {1'b0, s0_fire_q && s0_last_q} + {1'b0, s1_valid_q && s1_last_q};
  assign ifmap_ready = (state_q == ST_RUN) && (32'(fifo_free) > 32'(inflight));
  assign xfer        = i_ifmap_valid && ifmap_ready;

  assign col_at_tap = (32'(col_q) + 32'd1) >= 32'(f_q);
  assign fire       = col_at_tap && (ph_q == '0);
  assign col_last   = (col_q == wdt_q - IW_W'(1));
  assign ch_last    = (ch_q == c_q - CH_W'(1));

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    s_d       = s_q;
    wdt_d     = wdt_q;
    c_d       = c_q;
    col_d     = col_q;
    ch_d      = ch_q;
    ph_d      = ph_q;
    o_d       = o_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (cfg_ok) begin
            state_d = ST_RUN;
            f_d     = i_filter_width;
            s_d     = i_stride;
            wdt_d   = i_ifmap_width;
            c_d     = i_num_channels;
            col_d   = '0;
            ch_d    = '0;
            ph_d    = '0;
            o_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (col_at_tap) begin
            if (fire) o_d = o_q + OIDX_W'(1);
            ph_d = (ph_q == s_q - FW_W'(1)) ? '0 : ph_q + FW_W'(1);
          end
          if (col_last) begin
            col_d = '0;
            ph_d  = '0;
            o_d   = '0;
            ch_d  = ch_q + CH_W'(1);
            if (ch_last) begin
              ch_d    = '0;
              state_d = ST_DRAIN;
            end
          end else begin
            col_d = col_q + IW_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!s0_fire_q && !s1_valid_q && !fifo_valid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s0_fire_d  = xfer && fire;
  assign s0_first_d = (ch_q == '0);
  assign s0_last_d  = ch_last;
  assign s0_ch_d    = WCH_W'(ch_q);
  assign s0_o_d     = o_q;

  // Window element j holds the pixel j columns back; the first column of a channel flushes it.
  for (genvar k = 0; k < MAX_FILTER_WIDTH; k++) begin : g_win
    if (k == 0) begin : g_head
      assign win_d[0] = xfer ? i_ifmap_data : win_q[0];
    end else begin : g_tail
      assign win_d[k] = xfer ? ((col_q == '0) ? '0 : win_q[k-1]) : win_q[k];
    end
  end

  assign lane_sum[0] = '0;
  for (genvar k = 0; k < MAX_FILTER_WIDTH; k++) begin : g_lane
    logic [WCOL_W-1:0] tap_idx;
    assign tap_idx      = WCOL_W'(f_q - FW_W'(k + 1));
    assign lane_prod[k] = (32'(f_q) > k) ? win_q[tap_idx] * w_q[s0_ch_q][k] : '0;
    assign lane_sum[k+1] = lane_sum[k] + ACC_W'(lane_prod[k]);
  end
  assign s1_sum_d = lane_sum[MAX_FILTER_WIDTH];

  assign acc_new   = s1_first_q ? s1_sum_q : psum_q[s1_o_q] + s1_sum_q;
  assign acc_shift = acc_new >>> FRAC_BITS;
  assign push_data = DATA_WIDTH'(narrow_f(NARROW_W'(acc_shift), DATA_WIDTH, SAT_EN));
  assign push      = s1_valid_q && s1_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      f_q        <= '0;
      s_q        <= '0;
      wdt_q      <= '0;
      c_q        <= '0;
      col_q      <= '0;
      ch_q       <= '0;
      ph_q       <= '0;
      o_q        <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      win_q      <= '{default: '0};
      s0_fire_q  <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_ch_q    <= '0;
      s0_o_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_o_q     <= '0;
      s1_sum_q   <= '0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      s_q        <= s_d;
      wdt_q      <= wdt_d;
      c_q        <= c_d;
      col_q      <= col_d;
      ch_q       <= ch_d;
      ph_q       <= ph_d;
      o_q        <= o_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      win_q      <= win_d;
      s0_fire_q  <= s0_fire_d;
      s0_first_q <= s0_first_d;
      s0_last_q  <= s0_last_d;
      s0_ch_q    <= s0_ch_d;
      s0_o_q     <= s0_o_d;
      s1_valid_q <= s0_fire_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_last_q;
      s1_o_q     <= s0_o_q;
      s1_sum_q   <= s1_sum_d;
    end
  end

  // Weights and psum storage are deliberately left unreset; channel 0 overwrites psums.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && i_weight_valid
        && (32'(i_weight_col) < 32'(MAX_FILTER_WIDTH)) && (32'(i_weight_ch) < 32'(MAX_CHANNELS)))
      w_q[i_weight_ch][i_weight_col] <= i_weight_data;
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) psum_q[s1_o_q] <= acc_new;
  end

  conv_row_ofifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUT_FIFO_DEPTH)
  ) u_ofifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (i_psum_ready),
    .o_data      (o_psum_data),
    .o_valid     (fifo_valid),
    .o_free      (fifo_free)
  );

  assign o_psum_valid  = fifo_valid;
  assign o_ifmap_ready = ifmap_ready;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed self-checking bench for conv_row_engine (default parameters).
// Saturation expectations follow the CONV_ROW_SAT_EN define.
module tb_conv_row_engine;

`ifdef CONV_ROW_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               i_start;
  logic [4:0]         i_filter_width;
  logic [4:0]         i_stride;
  logic [6:0]         i_ifmap_width;
  logic [2:0]         i_num_channels;
  logic signed [15:0] i_weight_data;
  logic               i_weight_valid;
  logic [1:0]         i_weight_ch;
  logic [3:0]         i_weight_col;
  logic signed [15:0] i_ifmap_data;
  logic               i_ifmap_valid;
  logic               o_ifmap_ready;
  logic signed [15:0] o_psum_data;
  logic               o_psum_valid;
  logic               i_psum_ready;
  logic               o_busy;
  logic               o_done;
  logic               o_cfg_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int got[$];
  int stim[0:15];
  int expv[0:15];

  always #5 clk = ~clk;

  conv_row_engine dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_filter_width (i_filter_width),
    .i_stride       (i_stride),
    .i_ifmap_width  (i_ifmap_width),
    .i_num_channels (i_num_channels),
    .i_weight_data  (i_weight_data),
    .i_weight_valid (i_weight_valid),
    .i_weight_ch    (i_weight_ch),
    .i_weight_col   (i_weight_col),
    .i_ifmap_data   (i_ifmap_data),
    .i_ifmap_valid  (i_ifmap_valid),
    .o_ifmap_ready  (o_ifmap_ready),
    .o_psum_data    (o_psum_data),
    .o_psum_valid   (o_psum_valid),
    .i_psum_ready   (i_psum_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_cfg_err      (o_cfg_err)
  );

  // Outputs and done pulses are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset && o_psum_valid && i_psum_ready) got.push_back(int'(o_psum_data));
    if (reset && o_done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic loadWeight(input int ch, input int col, input int val);
    @(posedge clk); #1;
    i_weight_ch    = 2'(ch);
    i_weight_col   = 4'(col);
    i_weight_data  = 16'(val);
    i_weight_valid = 1'b1;
    @(posedge clk); #1;
    i_weight_valid = 1'b0;
  endtask

  task automatic startJob(input int f, input int s, input int w, input int c);
    @(posedge clk); #1;
    i_filter_width = 5'(f);
    i_stride       = 5'(s);
    i_ifmap_width  = 7'(w);
    i_num_channels = 3'(c);
    i_start        = 1'b1;
    @(posedge clk); #1;
    i_start        = 1'b0;
  endtask

  task automatic pushPixel(input int d);
    int cyc;
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    i_ifmap_data  = 16'(d);
    i_ifmap_valid = 1'b1;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      if (o_ifmap_ready) ok = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    i_ifmap_valid = 1'b0;
    checkOutput("pix_accept", int'(ok), 1);
  endtask

  task automatic waitDone(input string tag);
    int start_cnt;
    int cyc;
    start_cnt = done_cnt;
    cyc = 0;
    while (done_cnt == start_cnt && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput(tag, int'(done_cnt != start_cnt), 1);
  endtask

  task automatic applyStimulus(input int f, input int s, input int w, input int c, input int npix);
    startJob(f, s, w, c);
    checkOutput("busy_after_start", int'(o_busy), 1);
    got.delete();
    for (int i = 0; i < npix; i++) pushPixel(stim[i]);
  endtask

  task automatic checkResults(input string tag, input int n);
    checkOutput({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : -99999, expv[i]);
  endtask

  initial begin
    reset          = 1'b0;
    i_start        = 1'b0;
    i_filter_width = '0;
    i_stride       = '0;
    i_ifmap_width  = '0;
    i_num_channels = '0;
    i_weight_data  = '0;
    i_weight_valid = 1'b0;
    i_weight_ch    = '0;
    i_weight_col   = '0;
    i_ifmap_data   = '0;
    i_ifmap_valid  = 1'b0;
    i_psum_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", int'(o_ifmap_ready), 0);
    checkOutput("rst_valid", int'(o_psum_valid), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_done", int'(o_done), 0);
    checkOutput("rst_cfg_err", int'(o_cfg_err), 0);
    checkOutput("rst_data", int'(o_psum_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int ch = 0; ch < 2; ch++)
      for (int k = 0; k < 3; k++) loadWeight(ch, k, k + 1);

    $display("[TB] job F=3 S=1 W=5 C=1");
    for (int i = 0; i < 5; i++) stim[i] = i + 1;
    applyStimulus(3, 1, 5, 1, 5);
    waitDone("j1_done");
    @(posedge clk); #1;
    checkOutput("j1_done_width", int'(o_done), 0);
    expv[0] = 14; expv[1] = 20; expv[2] = 26;
    checkResults("j1", 3);

    $display("[TB] job F=3 S=1 W=5 C=2");
    for (int i = 0; i < 10; i++) stim[i] = (i % 5) + 1;
    applyStimulus(3, 1, 5, 2, 10);
    waitDone("j2_done");
    expv[0] = 28; expv[1] = 40; expv[2] = 52;
    checkResults("j2", 3);

    $display("[TB] job F=3 S=2 W=5 C=1");
    for (int i = 0; i < 5; i++) stim[i] = i + 1;
    applyStimulus(3, 2, 5, 1, 5);
    waitDone("j3_done");
    expv[0] = 14; expv[1] = 26;
    checkResults("j3", 2);

    $display("[TB] job F=1 narrowing");
    loadWeight(0, 0, 32767);
    stim[0] = 32767;
    applyStimulus(1, 1, 1, 1, 1);
    waitDone("j4_done");
    expv[0] = SAT_EXP;
    checkResults("j4", 1);

    $display("[TB] job F=2 S=1 W=10 C=1 with backpressure");
    loadWeight(0, 0, 1);
    for (int i = 0; i < 10; i++) stim[i] = i + 1;
    i_psum_ready = 1'b0;
    startJob(2, 1, 10, 1);
    got.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) pushPixel(stim[i]);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_low", int'(o_ifmap_ready), 0);
        checkOutput("bp_valid_high", int'(o_psum_valid), 1);
        checkOutput("bp_head", int'(o_psum_data), 5);
        @(posedge clk); #1;
        i_psum_ready = 1'b1;
      end
    join
    waitDone("j5_done");
    for (int o = 0; o < 9; o++) expv[o] = 3 * o + 5;
    checkResults("j5", 9);

    $display("[TB] illegal configuration");
    startJob(4, 1, 3, 1);
    checkOutput("cfg_err_pulse", int'(o_cfg_err), 1);
    checkOutput("cfg_err_busy", int'(o_busy), 0);
    @(posedge clk); #1;
    checkOutput("cfg_err_clear", int'(o_cfg_err), 0);
    checkOutput("cfg_err_busy2", int'(o_busy), 0);

    $display("[TB] reset mid-run");
    startJob(3, 1, 5, 1);
    pushPixel(1);
    pushPixel(2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", int'(o_busy), 0);
    checkOutput("mid_rst_ready", int'(o_ifmap_ready), 0);
    checkOutput("mid_rst_valid", int'(o_psum_valid), 0);
    checkOutput("mid_rst_data", int'(o_psum_data), 0);
    checkOutput("mid_rst_done", int'(o_done), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) loadWeight(0, k, k + 1);
    for (int i = 0; i < 5; i++) stim[i] = i + 1;
    applyStimulus(3, 1, 5, 1, 5);
    waitDone("j6_done");
    expv[0] = 14; expv[1] = 20; expv[2] = 26;
    checkResults("j6", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
